// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: store FIFO between the core data port and a single-port RAM.
// Stores retire into the buffer without stalling, loads are forwarded from the
// youngest matching entry, and the one RAM port is shared between load misses
// (higher priority) and draining the oldest buffered store.
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_wr,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_stall,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ready,
  output logic              buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  entry_addr_q [DEPTH];
  logic [ADDR_W-1:0]  entry_addr_d [DEPTH];
  logic [DATA_W-1:0]  entry_data_q [DEPTH];
  logic [DATA_W-1:0]  entry_data_d [DEPTH];

  logic               full;
  logic               is_load;
  logic               hit;
  logic [DATA_W-1:0]  hit_data;
  logic [PTR_W-1:0]   scan_idx;
  logic               load_miss;
  logic               load_done;
  logic               enq;
  logic               deq;

  // Scan valid entries oldest to youngest so the youngest matching store wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entry_addr_q[scan_idx] == core_addr)) begin
        hit      = 1'b1;
        hit_data = entry_data_q[scan_idx];
      end
    end
  end

  // Request classification; a simultaneous store and load counts as a store only.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    is_load   = core_rd && !core_wr;
    load_miss = is_load && !hit;
    load_done = (state_q == LOAD) && mem_ready;
    enq       = core_wr && !full;
    deq       = (state_q == DRAIN) && mem_ready;
  end

  // Next-state for FIFO storage, pointers, occupancy and the RAM port FSM.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    state_d      = state_q;
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;

    if (enq) begin
      entry_addr_d[tail_q] = core_addr;
      entry_data_d[tail_q] = core_wr_data;
      tail_d               = tail_q + PTR_W'(1);
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d = LOAD;
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          if (load_miss) begin
            state_d = LOAD;
          end else if (count_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        if (mem_ready) begin
          state_d = (count_q == '0) ? IDLE : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core and RAM facing outputs, decoded from registered state and current request.
  always_comb begin
    core_rd_data = '0;
    core_stall   = 1'b0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    buf_empty    = (count_q == '0);

    if (is_load) begin
      if (hit) begin
        core_rd_data = hit_data;
      end else if (load_done) begin
        core_rd_data = mem_rd_data;
      end
    end
    core_stall = (core_wr && full) || (load_miss && !load_done);

    if (state_q == DRAIN) begin
      mem_wr      = 1'b1;
      mem_addr    = entry_addr_q[head_q];
      mem_wr_data = entry_data_q[head_q];
    end else if (state_q == LOAD) begin
      mem_rd   = 1'b1;
      mem_addr = core_addr;
    end
  end

  // Control registers; reset drops every pending entry and any RAM request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity comes from count, so no reset is needed.
  always_ff @(posedge clk) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

endmodule
